// File: rtl/game_packet_rx.sv
// game_packet_rx
//   Receive-side framer for the player-to-player UART link. Pops bytes from
//   the uart RX FIFO, hunts for the sync byte, collects a 6-byte payload plus
//   check byte, and publishes player-2 state only when the frame verifies.
//
//   Frame: SYNC, B0..B5, CHK
//     B0 = x[11:4]           B1 = {x[3:0], y[11:8]}   B2 = y[7:0]
//     B3 = {hp, aggro}       B4 = {class, flip_h, game_start, 4'b0}
//     B5 = {1'b0, boss_hp}   reserved bits are ignored on receive
//
//   Build option: define GAME_RX_CRC8_EN to use CRC-8 (poly 0x07, init 0x00,
//   MSB-first over B0..B5) as the check byte; otherwise CHK = B0^B1^...^B5.
//   The TX packer must be built with the same setting.
//
// Ports
//   clk                 system clock
//   rst_n               synchronous reset, active-low
//   rx_empty            uart RX FIFO empty
//   r_data              uart RX FIFO head byte (valid while rx_empty=0)
//   rd_uart             FIFO pop, equal to !rx_empty
//   player_2_*          last verified remote player state
//   player2_game_start  remote game-start flag
//   boss_out_hp         remote boss HP
//   data_valid          1-cycle pulse when the outputs above were updated
//   link_alive          a good frame was seen within LINK_TIMEOUT_CYCLES
//   frame_err_cnt       saturating count of check failures and byte timeouts
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_HUNT    | discarding bytes until the sync byte arrives
// ST_PAYLOAD | collecting B0..B5 into the shadow fields, updating check acc
// ST_CHECK   | waiting for the check byte; verify then return to HUNT

module game_packet_rx #(
  parameter logic [7:0]  SYNC_BYTE           = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT_CYCLES = 65_000,
  parameter int unsigned LINK_TIMEOUT_CYCLES = 6_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_empty,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  output logic [11:0] player_2_x,
  output logic [11:0] player_2_y,
  output logic [3:0]  player_2_hp,
  output logic [3:0]  player_2_aggro,
  output logic [1:0]  player_2_class,
  output logic        player_2_flip_h,
  output logic        player2_game_start,
  output logic [6:0]  boss_out_hp,
  output logic        data_valid,
  output logic        link_alive,
  output logic [7:0]  frame_err_cnt
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT_CYCLES + 1);
  localparam int LT_W = $clog2(LINK_TIMEOUT_CYCLES + 1);

  localparam logic [BT_W-1:0] BT_MAX  = BT_W'(BYTE_TIMEOUT_CYCLES);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT_CYCLES - 1);
  localparam logic [LT_W-1:0] LT_MAX  = LT_W'(LINK_TIMEOUT_CYCLES);
  localparam logic [LT_W-1:0] LT_LAST = LT_W'(LINK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [2:0]      idx, idx_next;
  logic [7:0]      acc, acc_next;
  logic            shadow_we;
  logic            frame_good;
  logic            err_inc;
  logic            pop;
  logic            byte_tmr_hit;
  logic [BT_W-1:0] byte_tmr;
  logic [LT_W-1:0] link_tmr;

  logic [11:0]     sh_x;
  logic [11:0]     sh_y;
  logic [3:0]      sh_hp;
  logic [3:0]      sh_aggro;
  logic [1:0]      sh_class;
  logic            sh_flip_h;
  logic            sh_game_start;
  logic [6:0]      sh_boss_hp;

  // The FIFO is never back-pressured: any byte at the head is taken.
  assign pop     = !rx_empty;
  assign rd_uart = !rx_empty;

  // Fires on the cycle whose idle tick would bring the timer to the limit;
  // a byte in that same cycle takes precedence.
  assign byte_tmr_hit = (byte_tmr == BT_LAST);

  function automatic logic [7:0] acc_update(input logic [7:0] acc_in,
                                            input logic [7:0] din);
`ifdef GAME_RX_CRC8_EN
    logic [7:0] c;
    c = acc_in ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return acc_in ^ din;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    acc_next   = acc;
    shadow_we  = 1'b0;
    frame_good = 1'b0;
    err_inc    = 1'b0;
    case (state)
      ST_HUNT: begin
        if (pop && (r_data == SYNC_BYTE)) begin
          state_next = ST_PAYLOAD;
          idx_next   = 3'd0;
          acc_next   = 8'h00;
        end
      end
      ST_PAYLOAD: begin
        if (pop) begin
          // A sync-valued byte here is payload data, never a resync.
          shadow_we = 1'b1;
          acc_next  = acc_update(acc, r_data);
          if (idx == 3'd5) begin
            state_next = ST_CHECK;
          end else begin
            idx_next = idx + 3'd1;
          end
        end else if (byte_tmr_hit) begin
          state_next = ST_HUNT;
          err_inc    = 1'b1;
        end
      end
      ST_CHECK: begin
        if (pop) begin
          state_next = ST_HUNT;
          if (r_data == acc) frame_good = 1'b1;
          else               err_inc    = 1'b1;
        end else if (byte_tmr_hit) begin
          state_next = ST_HUNT;
          err_inc    = 1'b1;
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx                <= 3'd0;
      acc                <= 8'h00;
      sh_x               <= 12'h000;
      sh_y               <= 12'h000;
      sh_hp              <= 4'h0;
      sh_aggro           <= 4'h0;
      sh_class           <= 2'b00;
      sh_flip_h          <= 1'b0;
      sh_game_start      <= 1'b0;
      sh_boss_hp         <= 7'h00;
      player_2_x         <= 12'h000;
      player_2_y         <= 12'h000;
      player_2_hp        <= 4'h0;
      player_2_aggro     <= 4'h0;
      player_2_class     <= 2'b00;
      player_2_flip_h    <= 1'b0;
      player2_game_start <= 1'b0;
      boss_out_hp        <= 7'h00;
      data_valid         <= 1'b0;
      link_alive         <= 1'b0;
      frame_err_cnt      <= 8'h00;
      byte_tmr           <= '0;
      link_tmr           <= '0;
    end else begin
      idx <= idx_next;
      acc <= acc_next;

      if (shadow_we) begin
        case (idx)
          3'd0: sh_x[11:4] <= r_data;
          3'd1: begin
            sh_x[3:0]  <= r_data[7:4];
            sh_y[11:8] <= r_data[3:0];
          end
          3'd2: sh_y[7:0] <= r_data;
          3'd3: begin
            sh_hp    <= r_data[7:4];
            sh_aggro <= r_data[3:0];
          end
          3'd4: begin
            sh_class      <= r_data[7:6];
            sh_flip_h     <= r_data[5];
            sh_game_start <= r_data[4];
          end
          3'd5: sh_boss_hp <= r_data[6:0];
          default: ;
        endcase
      end

      // Outputs move only on a verified frame; failed frames leave them held.
      data_valid <= frame_good;
      if (frame_good) begin
        player_2_x         <= sh_x;
        player_2_y         <= sh_y;
        player_2_hp        <= sh_hp;
        player_2_aggro     <= sh_aggro;
        player_2_class     <= sh_class;
        player_2_flip_h    <= sh_flip_h;
        player2_game_start <= sh_game_start;
        boss_out_hp        <= sh_boss_hp;
      end

      if (err_inc && (frame_err_cnt != 8'hFF)) begin
        frame_err_cnt <= frame_err_cnt + 8'd1;
      end

      if (pop) begin
        byte_tmr <= '0;
      end else if (byte_tmr != BT_MAX) begin
        byte_tmr <= byte_tmr + 1'b1;
      end

      if (frame_good) begin
        link_tmr   <= '0;
        link_alive <= 1'b1;
      end else if (link_tmr != LT_MAX) begin
        link_tmr <= link_tmr + 1'b1;
        if (link_tmr == LT_LAST) link_alive <= 1'b0;
      end
    end
  end

endmodule
